// File: rtl/cfg_desc_reader_pkg.sv
// Shared constants for the configuration descriptor reader: word map,
// magic value, ISA bitmap positions and the reader FSM states.
package cfg_desc_reader_pkg;

    localparam int unsigned NumDescWords = 32;

    localparam logic [63:0] DESC_MAGIC = 64'h4356_4136_4346_4701;

    localparam logic [6:0] WORD_MAGIC       = 7'd0;
    localparam logic [6:0] WORD_XLEN_VLEN   = 7'd1;
    localparam logic [6:0] WORD_ISA         = 7'd2;
    localparam logic [6:0] WORD_ICACHE      = 7'd3;
    localparam logic [6:0] WORD_DCACHE      = 7'd4;
    localparam logic [6:0] WORD_UARCH       = 7'd5;
    localparam logic [6:0] WORD_HALT_ADDR   = 7'd6;
    localparam logic [6:0] WORD_EXC_ADDR    = 7'd7;
    localparam logic [6:0] WORD_RULE_COUNTS = 7'd8;
    localparam logic [6:0] WORD_REGION_BASE = 7'd16;

    localparam int unsigned ISA_RVA         = 0;
    localparam int unsigned ISA_RVB         = 1;
    localparam int unsigned ISA_RVC         = 2;
    localparam int unsigned ISA_RVF         = 3;
    localparam int unsigned ISA_RVD         = 4;
    localparam int unsigned ISA_RVH         = 5;
    localparam int unsigned ISA_RVV         = 6;
    localparam int unsigned ISA_RVS         = 7;
    localparam int unsigned ISA_RVU         = 8;
    localparam int unsigned ISA_RVZCB       = 9;
    localparam int unsigned ISA_RVZCMP      = 10;
    localparam int unsigned ISA_RVZICOND    = 11;
    localparam int unsigned ISA_CVXIF_EN    = 12;
    localparam int unsigned ISA_MMU_PRESENT = 13;
    localparam int unsigned ISA_DEBUG_EN    = 14;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } desc_state_e;

endpackage

// File: rtl/config_pkg.sv
// Core configuration record served by cfg_desc_reader. Only the fields the
// descriptor map exposes are carried here.
package config_pkg;

    typedef struct packed {
        logic [31:0]       XLEN;
        logic [31:0]       VLEN;
        logic              RVA;
        logic              RVB;
        logic              RVC;
        logic              RVF;
        logic              RVD;
        logic              RVH;
        logic              RVV;
        logic              RVS;
        logic              RVU;
        logic              RVZCB;
        logic              RVZCMP;
        logic              RVZiCond;
        logic              CvxifEn;
        logic              MmuPresent;
        logic              DebugEn;
        logic [31:0]       IcacheByteSize;
        logic [31:0]       IcacheSetAssoc;
        logic [31:0]       IcacheLineWidth;
        logic [31:0]       DcacheByteSize;
        logic [31:0]       DcacheSetAssoc;
        logic [31:0]       DcacheLineWidth;
        logic [31:0]       DCacheType;
        logic [31:0]       NrScoreboardEntries;
        logic [31:0]       NrCommitPorts;
        logic [31:0]       NrPMPEntries;
        logic [31:0]       AxiAddrWidth;
        logic [31:0]       AxiDataWidth;
        logic [63:0]       HaltAddress;
        logic [63:0]       ExceptionAddress;
        logic [31:0]       NrNonIdempotentRules;
        logic [31:0]       NrExecuteRegionRules;
        logic [31:0]       NrCachedRegionRules;
        logic [3:0][63:0]  CachedRegionAddrBase;
        logic [3:0][63:0]  CachedRegionLength;
        logic [3:0][63:0]  ExecuteRegionAddrBase;
        logic [3:0][63:0]  ExecuteRegionLength;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/cfg_desc_rom.sv
// Combinational descriptor lookup: word index -> {data, err}.
// Optional region table (words 16-31) enabled by CFG_DESC_READER_REGIONS_EN;
// without it those words report an error and word 8 reads zero.
module cfg_desc_rom #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
    input  logic [6:0]  i_index,
    output logic [63:0] o_data,
    output logic        o_err
);
    import cfg_desc_reader_pkg::*;

    logic [63:0] w_isa;

`ifdef CFG_DESC_READER_REGIONS_EN
    logic [1:0]  w_rule_k;
    logic        w_is_exec;
    logic        w_is_len;
    logic        w_rule_hit;
    logic [63:0] w_region_word;

    assign w_rule_k  = i_index[2:1];
    assign w_is_exec = i_index[3];
    assign w_is_len  = i_index[0];

    // Pick the region field and whether its rule number is populated
    always_comb begin
        w_rule_hit    = 1'b0;
        w_region_word = 64'd0;
        if (w_is_exec) begin
            w_rule_hit    = ({30'd0, w_rule_k} < CVA6Cfg.NrExecuteRegionRules);
            w_region_word = w_is_len ? CVA6Cfg.ExecuteRegionLength[w_rule_k]
                                     : CVA6Cfg.ExecuteRegionAddrBase[w_rule_k];
        end else begin
            w_rule_hit    = ({30'd0, w_rule_k} < CVA6Cfg.NrCachedRegionRules);
            w_region_word = w_is_len ? CVA6Cfg.CachedRegionLength[w_rule_k]
                                     : CVA6Cfg.CachedRegionAddrBase[w_rule_k];
        end
    end
`endif

    // Assemble the ISA feature bitmap; unlisted bits stay zero
    always_comb begin
        w_isa                  = 64'd0;
        w_isa[ISA_RVA]         = CVA6Cfg.RVA;
        w_isa[ISA_RVB]         = CVA6Cfg.RVB;
        w_isa[ISA_RVC]         = CVA6Cfg.RVC;
        w_isa[ISA_RVF]         = CVA6Cfg.RVF;
        w_isa[ISA_RVD]         = CVA6Cfg.RVD;
        w_isa[ISA_RVH]         = CVA6Cfg.RVH;
        w_isa[ISA_RVV]         = CVA6Cfg.RVV;
        w_isa[ISA_RVS]         = CVA6Cfg.RVS;
        w_isa[ISA_RVU]         = CVA6Cfg.RVU;
        w_isa[ISA_RVZCB]       = CVA6Cfg.RVZCB;
        w_isa[ISA_RVZCMP]      = CVA6Cfg.RVZCMP;
        w_isa[ISA_RVZICOND]    = CVA6Cfg.RVZiCond;
        w_isa[ISA_CVXIF_EN]    = CVA6Cfg.CvxifEn;
        w_isa[ISA_MMU_PRESENT] = CVA6Cfg.MmuPresent;
        w_isa[ISA_DEBUG_EN]    = CVA6Cfg.DebugEn;
    end

    // Word map decode; indices past the table return zero with err set
    always_comb begin
        o_data = 64'd0;
        o_err  = 1'b0;
        if ({25'd0, i_index} >= NumDescWords) begin
            o_err = 1'b1;
        end else if (i_index >= WORD_REGION_BASE) begin
`ifdef CFG_DESC_READER_REGIONS_EN
            o_data = w_rule_hit ? w_region_word : 64'd0;
`else
            o_err  = 1'b1;
`endif
        end else begin
            case (i_index)
                WORD_MAGIC:     o_data = DESC_MAGIC;
                WORD_XLEN_VLEN: o_data = {CVA6Cfg.XLEN, CVA6Cfg.VLEN};
                WORD_ISA:       o_data = w_isa;
                WORD_ICACHE:    o_data = {CVA6Cfg.IcacheByteSize,
                                          CVA6Cfg.IcacheSetAssoc[15:0],
                                          CVA6Cfg.IcacheLineWidth[15:0]};
                WORD_DCACHE:    o_data = {CVA6Cfg.DcacheByteSize,
                                          CVA6Cfg.DcacheSetAssoc[15:0],
                                          CVA6Cfg.DcacheLineWidth[15:0]};
                WORD_UARCH:     o_data = {CVA6Cfg.DCacheType[7:0],
                                          CVA6Cfg.NrScoreboardEntries[7:0],
                                          CVA6Cfg.NrCommitPorts[7:0],
                                          CVA6Cfg.NrPMPEntries[7:0],
                                          CVA6Cfg.AxiAddrWidth[15:0],
                                          CVA6Cfg.AxiDataWidth[15:0]};
                WORD_HALT_ADDR: o_data = CVA6Cfg.HaltAddress;
                WORD_EXC_ADDR:  o_data = CVA6Cfg.ExceptionAddress;
`ifdef CFG_DESC_READER_REGIONS_EN
                WORD_RULE_COUNTS: o_data = {CVA6Cfg.NrNonIdempotentRules[15:0],
                                            CVA6Cfg.NrExecuteRegionRules[15:0],
                                            CVA6Cfg.NrCachedRegionRules[15:0],
                                            16'h0};
`endif
                default:        o_data = 64'd0;
            endcase
        end
    end

endmodule

// File: rtl/cfg_desc_reader.sv
// Burst reader for the core configuration descriptor. A request names a
// first word and a beat count; beats stream out through a registered
// valid/ready response port, one per consumed beat.
// Optional feature macro: CFG_DESC_READER_REGIONS_EN (region table words).
module cfg_desc_reader #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [5:0]  req_addr_i,
    input  logic [3:0]  req_len_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        rsp_last_o
);
    import cfg_desc_reader_pkg::*;

    desc_state_e r_state;
    desc_state_e w_state_nxt;
    logic [6:0]  r_idx;
    logic [6:0]  w_idx_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [3:0]  r_len;
    logic [3:0]  w_len_nxt;
    logic        r_req_ready;
    logic        w_req_ready_nxt;
    logic        r_rsp_valid;
    logic        w_rsp_valid_nxt;
    logic [63:0] r_rsp_data;
    logic [63:0] w_rsp_data_nxt;
    logic        r_rsp_err;
    logic        w_rsp_err_nxt;
    logic        r_rsp_last;
    logic        w_rsp_last_nxt;

    logic [6:0]  w_rom_idx;
    logic [63:0] w_rom_data;
    logic        w_rom_err;
    logic        w_accept;
    logic        w_consume;

    assign w_accept  = req_valid_i & r_req_ready;
    assign w_consume = r_rsp_valid & rsp_ready_i;

    // Look up the word for the beat about to be loaded: the request's first
    // word while idle, otherwise the word after the one currently shown
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_rom_idx = {1'b0, req_addr_i};
        end else begin
            w_rom_idx = r_idx + 7'd1;
        end
    end

    cfg_desc_rom #(
        .CVA6Cfg (CVA6Cfg)
    ) u_rom (
        .i_index (w_rom_idx),
        .o_data  (w_rom_data),
        .o_err   (w_rom_err)
    );

    // Next state and next values of every registered output
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_cnt_nxt       = r_cnt;
        w_len_nxt       = r_len;
        w_req_ready_nxt = r_req_ready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_last_nxt  = r_rsp_last;
        case (r_state)
            ST_IDLE: begin
                w_req_ready_nxt = 1'b1;
                if (w_accept) begin
                    w_state_nxt     = ST_RESP;
                    w_idx_nxt       = {1'b0, req_addr_i};
                    w_cnt_nxt       = 4'd0;
                    w_len_nxt       = req_len_i;
                    w_req_ready_nxt = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = w_rom_data;
                    w_rsp_err_nxt   = w_rom_err;
                    w_rsp_last_nxt  = (req_len_i == 4'd0);
                end else begin
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            ST_RESP: begin
                w_req_ready_nxt = 1'b0;
                if (w_consume) begin
                    if (r_rsp_last) begin
                        // Ready rises only after this edge, so no request
                        // can overlap the final beat
                        w_state_nxt     = ST_IDLE;
                        w_rsp_valid_nxt = 1'b0;
                        w_rsp_last_nxt  = 1'b0;
                        w_req_ready_nxt = 1'b1;
                    end else begin
                        w_idx_nxt       = r_idx + 7'd1;
                        w_cnt_nxt       = r_cnt + 4'd1;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_data_nxt  = w_rom_data;
                        w_rsp_err_nxt   = w_rom_err;
                        w_rsp_last_nxt  = ((r_cnt + 4'd1) == r_len);
                    end
                end else begin
                    w_rsp_valid_nxt = r_rsp_valid;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_req_ready_nxt = 1'b0;
                w_rsp_valid_nxt = 1'b0;
                w_rsp_last_nxt  = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Beat bookkeeping and registered response/handshake outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idx       <= 7'd0;
            r_cnt       <= 4'd0;
            r_len       <= 4'd0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 64'd0;
            r_rsp_err   <= 1'b0;
            r_rsp_last  <= 1'b0;
        end else begin
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_len       <= w_len_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_last  <= w_rsp_last_nxt;
        end
    end

    assign req_ready_o = r_req_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_err_o   = r_rsp_err;
    assign rsp_last_o  = r_rsp_last;

endmodule

// File: tb/tb_cfg_desc_reader.sv
// Self-checking bench for cfg_desc_reader: expected beats are pushed to a
// scoreboard queue when a request is issued and compared as beats are consumed.
module tb_cfg_desc_reader;
    import config_pkg::*;

    function automatic cva6_cfg_t mk_cfg();
        cva6_cfg_t c;
        c = '0;
        c.XLEN = 32'd64;  c.VLEN = 32'd64;
        c.RVA = 1'b1; c.RVC = 1'b1; c.RVF = 1'b1; c.RVD = 1'b1;
        c.RVS = 1'b1; c.RVU = 1'b1; c.RVZCB = 1'b1; c.MmuPresent = 1'b1;
        c.DebugEn = 1'b1;
        c.IcacheByteSize = 32'd65536; c.IcacheSetAssoc = 32'd16; c.IcacheLineWidth = 32'd128;
        c.DcacheByteSize = 32'd65536; c.DcacheSetAssoc = 32'd16; c.DcacheLineWidth = 32'd128;
        c.DCacheType = 32'd3; c.NrScoreboardEntries = 32'd8; c.NrCommitPorts = 32'd2;
        c.NrPMPEntries = 32'd8; c.AxiAddrWidth = 32'd64; c.AxiDataWidth = 32'd64;
        c.HaltAddress = 64'h800; c.ExceptionAddress = 64'h808;
        c.NrNonIdempotentRules = 32'd2; c.NrExecuteRegionRules = 32'd3;
        c.NrCachedRegionRules = 32'd1;
        for (int k = 0; k < 4; k++) begin
            c.CachedRegionAddrBase[k]  = 64'h8000_0000 + 64'(k) * 64'h1000_0000;
            c.CachedRegionLength[k]    = 64'h0400_0000 + 64'(k);
            c.ExecuteRegionAddrBase[k] = 64'h0001_0000 + 64'(k) * 64'h0100_0000;
            c.ExecuteRegionLength[k]   = 64'h0000_2000 + 64'(k);
        end
        return c;
    endfunction

    localparam cva6_cfg_t TB_CFG = mk_cfg();

    typedef struct {
        logic [63:0] data;
        logic        err;
        logic        last;
    } beat_t;

    beat_t sb_q[$];
    int    checks = 0;
    int    errors = 0;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [5:0]  req_addr_i;
    logic [3:0]  req_len_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [63:0] rsp_data_o;
    logic        rsp_err_o;
    logic        rsp_last_o;

    always #5 clk = ~clk;

    cfg_desc_reader #(.CVA6Cfg(TB_CFG)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_len_i   (req_len_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o),
        .rsp_last_o  (rsp_last_o)
    );

    // Reference word map, written from the descriptor table description
    function automatic void exp_word(input int idx, output logic [63:0] d, output logic e);
`ifdef CFG_DESC_READER_REGIONS_EN
        int off;
        int k;
        logic [31:0] nr;
`endif
        d = 64'd0;
        e = 1'b0;
        if (idx >= 32) begin
            e = 1'b1;
        end else if (idx >= 16) begin
`ifdef CFG_DESC_READER_REGIONS_EN
            off = idx - 16;
            k   = (off % 8) / 2;
            nr  = (off >= 8) ? TB_CFG.NrExecuteRegionRules : TB_CFG.NrCachedRegionRules;
            if (k < int'(nr)) begin
                if (off >= 8) d = (off % 2 == 1) ? TB_CFG.ExecuteRegionLength[k] : TB_CFG.ExecuteRegionAddrBase[k];
                else          d = (off % 2 == 1) ? TB_CFG.CachedRegionLength[k]  : TB_CFG.CachedRegionAddrBase[k];
            end
`else
            e = 1'b1;
`endif
        end else begin
            case (idx)
                0: d = 64'h4356_4136_4346_4701;
                1: d = {TB_CFG.XLEN, TB_CFG.VLEN};
                2: d = {49'd0, TB_CFG.DebugEn, TB_CFG.MmuPresent, TB_CFG.CvxifEn,
                        TB_CFG.RVZiCond, TB_CFG.RVZCMP, TB_CFG.RVZCB, TB_CFG.RVU,
                        TB_CFG.RVS, TB_CFG.RVV, TB_CFG.RVH, TB_CFG.RVD, TB_CFG.RVF,
                        TB_CFG.RVC, TB_CFG.RVB, TB_CFG.RVA};
                3: d = {32'd65536, 16'd16, 16'd128};
                4: d = {32'd65536, 16'd16, 16'd128};
                5: d = {8'd3, 8'd8, 8'd2, 8'd8, 16'd64, 16'd64};
                6: d = 64'h800;
                7: d = 64'h808;
`ifdef CFG_DESC_READER_REGIONS_EN
                8: d = {16'd2, 16'd3, 16'd1, 16'h0};
`endif
                default: d = 64'd0;
            endcase
        end
    endfunction

    task automatic push_burst(input int addr, input int len);
        logic [63:0] d;
        logic        e;
        for (int i = 0; i <= len; i++) begin
            exp_word(addr + i, d, e);
            sb_q.push_back('{data: d, err: e, last: (i == len)});
        end
    endtask

    // Issue one request (from a negedge); checks first-beat latency
    task automatic send_req(input int addr, input int len);
        int budget;
        budget = 0;
        while (req_ready_o !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_wait: got %b expected 1", req_ready_o);
        end
        req_valid_i = 1'b1;
        req_addr_i  = addr[5:0];
        req_len_i   = len[3:0];
        push_burst(addr, len);
        @(negedge clk);
        req_valid_i = 1'b0;
        checks++;
        if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL first_beat_latency: valid=%b ready=%b expected valid=1 ready=0",
                     rsp_valid_o, req_ready_o);
        end
    endtask

    // Consume beats until the scoreboard empties; mode 1 = random ready
    task automatic drain(input int mode);
        int    budget;
        beat_t eb;
        budget = 0;
        while (sb_q.size() > 0 && budget < 400) begin
            rsp_ready_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rsp_valid_o === 1'b1 && rsp_ready_i === 1'b1) begin
                eb = sb_q.pop_front();
                checks++;
                if (rsp_data_o !== eb.data || rsp_err_o !== eb.err || rsp_last_o !== eb.last) begin
                    errors++;
                    $display("FAIL beat: got data=%h err=%b last=%b expected data=%h err=%b last=%b",
                             rsp_data_o, rsp_err_o, rsp_last_o, eb.data, eb.err, eb.last);
                end
            end
            @(negedge clk);
            budget++;
        end
        rsp_ready_i = 1'b0;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats left expected 0", sb_q.size());
            sb_q.delete();
        end
        checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL burst_end: valid=%b ready=%b expected valid=0 ready=1",
                     rsp_valid_o, req_ready_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid_o !== 1'b0 || rsp_data_o !== 64'd0 || rsp_err_o !== 1'b0 ||
            rsp_last_o !== 1'b0 || req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: valid=%b data=%h err=%b last=%b ready=%b expected all 0",
                     rsp_valid_o, rsp_data_o, rsp_err_o, rsp_last_o, req_ready_o);
        end
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_magic();
        send_req(0, 0);
        drain(0);
    endtask

    task automatic test_dcache();
        send_req(3, 1);
        drain(0);
    endtask

    task automatic test_region_edge();
        send_req(30, 3);
        drain(1);
    endtask

    task automatic test_stall();
        send_req(6, 1);
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid_o !== 1'b1 || rsp_data_o !== 64'h800 || rsp_err_o !== 1'b0 || rsp_last_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: valid=%b data=%h err=%b last=%b expected 1 800 0 0",
                         rsp_valid_o, rsp_data_o, rsp_err_o, rsp_last_o);
            end
            @(negedge clk);
        end
        drain(0);
    endtask

    task automatic test_ignore_in_resp();
        send_req(2, 2);
        req_valid_i = 1'b1;
        req_addr_i  = 6'd0;
        req_len_i   = 4'd5;
        drain(1);
        req_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL resp_req_ignored: valid=%b expected 0", rsp_valid_o);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [63:0] d;
        logic        e;
        send_req(0, 15);
        rsp_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        exp_word(2, d, e);
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_data_o !== d) begin
            errors++;
            $display("FAIL beat2_before_reset: valid=%b data=%h expected 1 %h", rsp_valid_o, rsp_data_o, d);
        end
        rst_i = 1'b1;
        rsp_ready_i = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: valid=%b ready=%b expected 0 0", rsp_valid_o, req_ready_o);
        end
        rst_i = 1'b0;
        sb_q.delete();
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL residual_beat: valid=%b expected 0", rsp_valid_o);
            end
        end
        rsp_ready_i = 1'b0;
        send_req(1, 0);
        checks++;
        if (rsp_data_o !== {32'd64, 32'd64} || rsp_last_o !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_word1: data=%h last=%b expected %h 1",
                     rsp_data_o, rsp_last_o, {32'd64, 32'd64});
        end
        drain(0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 20; n++) begin
            send_req(int'($urandom_range(0, 63)), int'($urandom_range(0, 15)));
            drain((n % 3 == 0) ? 0 : 1);
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_addr_i  = 6'd0;
        req_len_i   = 4'd0;
        rsp_ready_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_magic();
        test_dcache();
        test_region_edge();
        test_stall();
        test_ignore_in_resp();
        test_reset_mid_burst();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
